// File: rtl/flt2int_seq.sv
// Sequential half-precision to 16-bit two's-complement converter (start/done handshake).
// Optional macro FLT2INT_ROUND_EN: round-half-to-even on right shifts instead of truncation.
module flt2int_seq #(
    parameter int EXP_BIAS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] flt_in,
    output logic [15:0] int_out,
    output logic        done,
    output logic        ovf,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // E_UNITY: exponent at which {1,mant} is already the integer magnitude.
    localparam int E_UNITY = EXP_BIAS + 10;
    localparam int E_SAT   = EXP_BIAS + 15;
`ifdef FLT2INT_ROUND_EN
    localparam int RSH_LO  = EXP_BIAS - 1;
`else
    localparam int RSH_LO  = EXP_BIAS;
`endif

    state_t      r_state;
    logic [15:0] r_flt;
    logic [15:0] r_work;
    logic [3:0]  r_count;
    logic        r_left;
    logic        r_sign;
    logic        r_sat;
`ifdef FLT2INT_ROUND_EN
    logic        r_guard;
    logic        r_sticky;
`endif

    int          w_e;
    logic [10:0] w_m;
    logic [15:0] w_work0;
    logic [3:0]  w_s;
    logic        w_left;
    logic        w_sat;
    logic [15:0] w_mag;
    logic [15:0] w_result;

    assign o_state = r_state;

    // Exponent decode of the latched operand, consumed on the LOAD exit edge.
    always_comb begin
        w_e     = int'(r_flt[14:10]);
        w_m     = {1'b1, r_flt[9:0]};
        w_work0 = 16'h0000;
        w_s     = 4'd0;
        w_left  = 1'b0;
        w_sat   = 1'b0;
        if (w_e == 0 || w_e < RSH_LO) begin
            w_work0 = 16'h0000;
        end else if (w_e < E_UNITY) begin
            w_work0 = {5'b0, w_m};
            w_s     = 4'(E_UNITY - w_e);
        end else if (w_e == E_UNITY) begin
            w_work0 = {5'b0, w_m};
        end else if (w_e < E_SAT) begin
            w_work0 = {5'b0, w_m};
            w_s     = 4'(w_e - E_UNITY);
            w_left  = 1'b1;
        end else if (w_e == E_SAT && r_flt[15] && r_flt[9:0] == 10'd0) begin
            // Most-negative integer encoding; negating 0x8000 yields 0x8000.
            w_work0 = 16'h8000;
        end else begin
            w_sat   = 1'b1;
        end
    end

    always_comb begin
`ifdef FLT2INT_ROUND_EN
        w_mag = r_work + {15'd0, r_guard & (r_sticky | r_work[0])};
`else
        w_mag = r_work;
`endif
        if (r_sat) begin
            w_result = r_sign ? 16'h8000 : 16'h7FFF;
        end else if (r_sign) begin
            w_result = ~w_mag + 16'd1;
        end else begin
            w_result = w_mag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_flt    <= 16'h0000;
            r_work   <= 16'h0000;
            r_count  <= 4'd0;
            r_left   <= 1'b0;
            r_sign   <= 1'b0;
            r_sat    <= 1'b0;
            int_out  <= 16'h0000;
            done     <= 1'b0;
            ovf      <= 1'b0;
`ifdef FLT2INT_ROUND_EN
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_flt   <= flt_in;
                        done    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        r_flt <= flt_in;
                    end else begin
                        r_work   <= w_work0;
                        r_count  <= w_s;
                        r_left   <= w_left;
                        r_sat    <= w_sat;
                        r_sign   <= r_flt[15];
`ifdef FLT2INT_ROUND_EN
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
`endif
                        r_state  <= (w_s != 4'd0) ? S_SHIFT : S_FIX;
                    end
                end
                S_SHIFT: begin
                    if (r_left) begin
                        r_work <= r_work << 1;
                    end else begin
                        r_work <= r_work >> 1;
`ifdef FLT2INT_ROUND_EN
                        r_guard  <= r_work[0];
                        r_sticky <= r_sticky | r_guard;
`endif
                    end
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    int_out <= w_result;
                    ovf     <= r_sat;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flt2int_seq.sv
// Directed bench for flt2int_seq: drivers push expected {ovf,int_out} and latency,
// a done-edge monitor pops and compares.
module tb_flt2int_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] flt_in;
    logic [15:0] int_out;
    logic        done;
    logic        ovf;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int push_cnt = 0;
    int resp_cnt = 0;
    logic done_prev = 1'b0;

    logic [16:0] exp_q[$];
    int          lat_q[$];
    int          e0_q[$];
    logic [15:0] flt_q[$];

    flt2int_seq #(.EXP_BIAS(15)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flt_in  (flt_in),
        .int_out (int_out),
        .done    (done),
        .ovf     (ovf),
        .o_state (o_state)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [15:0] flt, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s flt=%h got %0h expected %0h", name, flt, got, exp);
        end
    endtask

    // Driver: hold start for 'hold' edges, only the last edge carries f.
    task automatic issue(input logic [15:0] f, input int hold, input logic [15:0] exp_val,
                         input logic exp_ovf, input int lat);
        for (int i = 0; i < hold; i++) begin
            start  = 1'b1;
            flt_in = (i == hold - 1) ? f : 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        exp_q.push_back({exp_ovf, exp_val});
        lat_q.push_back(lat);
        e0_q.push_back(edge_cnt + 1);
        flt_q.push_back(f);
        push_cnt++;
    endtask

    task automatic wait_resp();
        int guard = 0;
        while (resp_cnt < push_cnt && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (resp_cnt < push_cnt) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done got %0d responses expected %0d", resp_cnt, push_cnt);
            exp_q.delete();
            lat_q.delete();
            e0_q.delete();
            flt_q.delete();
            resp_cnt = push_cnt;
        end
    endtask

    task automatic convert(input logic [15:0] f, input int hold, input logic [15:0] exp_val,
                           input logic exp_ovf, input int lat);
        issue(f, hold, exp_val, exp_ovf, lat);
        wait_resp();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare on each rising done, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got int_out %h expected no response", int_out);
            end else begin
                logic [16:0] e;
                int          l;
                int          e0;
                logic [15:0] f;
                e  = exp_q.pop_front();
                l  = lat_q.pop_front();
                e0 = e0_q.pop_front();
                f  = flt_q.pop_front();
                check("int_out", f, int'(int_out), int'(e[15:0]));
                check("ovf", f, int'(ovf), int'(e[16]));
                check("latency", f, edge_cnt - e0, l);
                resp_cnt++;
            end
        end
        done_prev = done;
    end

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        flt_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_int_out", 16'h0000, int'(int_out), 0);
        check("reset_done", 16'h0000, int'(done), 0);
        check("reset_ovf", 16'h0000, int'(ovf), 0);
        check("reset_state", 16'h0000, int'(o_state), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        convert(16'h3C00, 2, 16'h0001, 1'b0, 11);
        convert(16'h77F0, 1, 16'h7F00, 1'b0, 5);
        convert(16'hD400, 1, 16'hFFC0, 1'b0, 5);
        convert(16'hF800, 1, 16'h8000, 1'b0, 1);
        convert(16'h7800, 1, 16'h7FFF, 1'b1, 1);
        convert(16'hFC00, 1, 16'h8000, 1'b1, 1);
        convert(16'h0000, 1, 16'h0000, 1'b0, 1);
        convert(16'h8000, 1, 16'h0000, 1'b0, 1);
        convert(16'h6400, 1, 16'h0400, 1'b0, 1);
        convert(16'hC400, 1, 16'hFFFC, 1'b0, 9);
        convert(16'h4100, 1, 16'h0002, 1'b0, 10);
`ifdef FLT2INT_ROUND_EN
        convert(16'h3E00, 1, 16'h0002, 1'b0, 11);
        convert(16'h3900, 1, 16'h0001, 1'b0, 12);
        convert(16'h3800, 1, 16'h0000, 1'b0, 12);
        convert(16'hBE00, 1, 16'hFFFE, 1'b0, 11);
        convert(16'h3BFF, 1, 16'h0001, 1'b0, 12);
`else
        convert(16'h3E00, 1, 16'h0001, 1'b0, 11);
        convert(16'h3900, 1, 16'h0000, 1'b0, 1);
        convert(16'h3800, 1, 16'h0000, 1'b0, 1);
        convert(16'hBE00, 1, 16'hFFFF, 1'b0, 11);
        convert(16'h3BFF, 1, 16'h0000, 1'b0, 1);
`endif

        // Start held 5 edges with changing operand: only the last one counts.
        convert(16'h4400, 5, 16'h0004, 1'b0, 9);

        // Start pulse during SHIFT must be ignored.
        issue(16'h3C00, 1, 16'h0001, 1'b0, 11);
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        flt_in = 16'h4400;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_resp();
        repeat (3) @(posedge clk);
        #1;

        // Saturated result first so the abort has non-zero outputs to clear.
        convert(16'h7800, 1, 16'h7FFF, 1'b1, 1);
        start  = 1'b1;
        flt_in = 16'h3C00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_done", 16'h3C00, int'(done), 0);
        check("abort_int_out", 16'h3C00, int'(int_out), 0);
        check("abort_ovf", 16'h3C00, int'(ovf), 0);
        check("abort_state", 16'h3C00, int'(o_state), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 16'h3C00, int'(done), 0);
        convert(16'h4400, 1, 16'h0004, 1'b0, 9);

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expected got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flt2int_seq.md
Name: flt2int_seq

Overview:
- Downstream companion to the int2flt converter.
- Takes a 16-bit half-precision value (1 sign, 5 exponent with bias 15, 10 mantissa) in the format int2flt produces and converts it back to a 16-bit two's-complement integer.
- Multi-cycle shift-based datapath with a start/done handshake, matching the program-level start/done convention.
- Allows round-trip checking of int2flt results in hardware.

Parameters:
- EXP_BIAS, 15: exponent bias. All exponent thresholds below are stated for 15 and scale as EXP_BIAS+k.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- start  input  1  level request; high loads flt_in.
- flt_in  input  16  float operand {sign, exp[4:0], mant[9:0]}.
- int_out  output  16  two's-complement result.
- done  output  1  result valid; stays high until the next start.
- ovf  output  1  result was saturated; valid while done=1.

Behaviour:
- Reset values: state=IDLE, int_out=16'h0000, done=0, ovf=0, internal shift count=0.
- Reset mid-operation aborts the conversion; no partial result is written.
- States:
  - IDLE: waits for start.
  - LOAD: while start=1, re-latch flt_in every cycle; done=0.
  - SHIFT: one 1-bit shift per edge of the 16-bit working register; decrement count.
  - FIX: apply sign, register int_out and ovf.
  - DONE: done=1, hold outputs.
- Transitions:
  - IDLE or DONE, start=1 → LOAD.
  - LOAD, start=0 (edge e0) → SHIFT if s>0, else FIX.
  - SHIFT → FIX on the edge where count reaches 0.
  - FIX → DONE.
- Latency: done rises exactly s+1 edges after e0.
- int_out holds its previous value until FIX. It changes only on FIX→DONE.
- Working value: m = {1,mant} (11 bits).
- Exponent decode (e = exp field, unsigned):
  - e=0 (zero/subnormal): result 0, s=0.
  - 1 ≤ e ≤ 14: result 0, s=0 (see optional feature for e=14).
  - 15 ≤ e ≤ 24: right shift, s=25−e (1..10).
  - e=25: s=0, result m.
  - 26 ≤ e ≤ 29: left shift, s=e−25 (1..4). Maximum result is 0x7FF0, so no overflow.
  - e=30, sign=1, mant=0: result 0x8000, ovf=0, s=0 (the max-negative encoding produced by int2flt).
  - e≥30 otherwise (including e=31 inf/NaN): saturate, s=0, ovf=1. sign=0 → 0x7FFF; sign=1 → 0x8000.
- Sign: when sign=1 and the magnitude is not saturated, int_out = ~mag+1.
- −0 (0x8000 input) → 0x0000.
- A start arriving during SHIFT or FIX is ignored. It is accepted only in IDLE or DONE.

Optional Feature:
- Macro: FLT2INT_ROUND_EN.
- Defined: round-half-to-even on right shifts.
  - Track guard (last bit shifted out) and sticky (OR of all earlier shifted-out bits).
  - In FIX, increment the magnitude if guard & (sticky | lsb), before negation.
  - e=14 is also handled as a right shift with s=11; e ≤ 13 still gives 0.
- Undefined: truncation toward zero; guard/sticky logic is absent; e=14 gives 0 with s=0.

Test Plan:
- flt_in=0x3C00 (1.0), start high 2 cycles then low → int_out=0x0001, done exactly 11 edges after e0, ovf=0.
- flt_in=0x77F0 → int_out=0x7F00, done 5 edges after e0. flt_in=0xD400 → int_out=0xFFC0 (−64), done 5 edges after e0.
- Boundary cases:
  - flt_in=0xF800 → int_out=0x8000, ovf=0, done 1 edge after e0.
  - flt_in=0x7800 → int_out=0x7FFF, ovf=1.
  - flt_in=0xFC00 → int_out=0x8000, ovf=1.
  - flt_in=0x0000 → int_out=0x0000.
- Rounding, truncation build: 0x3E00 (1.5) → 0x0001; 0x3900 (0.625) → 0x0000; 0x4100 (2.5) → 0x0002.
- Rounding, FLT2INT_ROUND_EN build: 0x3E00 → 0x0002; 0x3900 → 0x0001; 0x3800 (0.5) → 0x0000; 0x4100 → 0x0002; 0xBE00 → 0xFFFE.
- Handshake and reset:
  - Hold start high 5 cycles with flt_in changing; only the last value is converted.
  - Pull reset low during SHIFT of 0x3C00 → done=0 and int_out=0 immediately.
  - After reset release, a new start with 0x4400 → int_out=0x0004.
